// File: rtl/fifo_ser_pkg.sv
// Shared types and constants for the FIFO-fed word serializer.
// Holds the FSM state encoding and the legal stop-bit range.
package fifo_ser_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      START,
      DATA,
      PARITY,
      STOP
   } ser_state_t;

   localparam int STOP_BITS_MIN = 1;
   localparam int STOP_BITS_MAX = 2;

   function automatic bit stop_bits_legal(input int n);
      return (n >= STOP_BITS_MIN) && (n <= STOP_BITS_MAX);
   endfunction

endpackage

// File: rtl/ser_bit_timer.sv
// Baud divider: counts CLKS_PER_BIT cycles while run is high and flags the
// last cycle of every bit period with bit_tick.
module ser_bit_timer #(
   parameter int CLKS_PER_BIT = 8
) (
   input  logic clk,
   input  logic rstn,
   input  logic run,
   output logic bit_tick
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] baud_cnt_reg;

   assign bit_tick = run && (baud_cnt_reg == LAST_CNT);

   // Held at zero while idle so every bit period starts on a full count.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         baud_cnt_reg <= '0;
      end else if (!run || bit_tick) begin
         baud_cnt_reg <= '0;
      end else begin
         baud_cnt_reg <= baud_cnt_reg + CW'(1);
      end
   end

endmodule

// File: rtl/fifo_word_serializer.sv
// Pulls words from a registered-output sync FIFO and sends each one as a
// UART-style frame: start, DWIDTH data bits LSB first, optional even parity, stop.
module fifo_word_serializer
   import fifo_ser_pkg::*;
#(
   parameter int DWIDTH       = 16,
   parameter int CLKS_PER_BIT = 8,
   parameter int PARITY_EN    = 1,
   parameter int STOP_BITS    = 1
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              en,
   input  logic              fifo_empty,
   input  logic [DWIDTH-1:0] fifo_dout,
   output logic              fifo_rd_en,
   output logic              tx,
   output logic              busy,
   output logic              frame_done
);

   localparam int BW = $clog2(DWIDTH + 1);
   localparam logic [BW-1:0] LAST_BIT  = BW'(DWIDTH - 1);
   localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

   if (!stop_bits_legal(STOP_BITS)) begin : g_bad_stop_bits
      $error("fifo_word_serializer: STOP_BITS must be 1 or 2");
   end

   ser_state_t        state_reg, state_next;
   logic [DWIDTH-1:0] shift_reg, shift_next;
   logic              parity_reg, parity_next;
   logic [BW-1:0]     bit_cnt_reg, bit_cnt_next;
   logic              tx_reg, tx_next;
   logic              rd_en_reg;
   logic              frame_done_reg, frame_done_next;
   logic              run;
   logic              bit_tick;

   assign run = (state_reg == START) || (state_reg == DATA) ||
                (state_reg == PARITY) || (state_reg == STOP);

   ser_bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_bit_timer (
      .clk     (clk),
      .rstn    (rstn),
      .run     (run),
      .bit_tick(bit_tick)
   );

   // tx is computed from the next state so the registered line lines up
   // exactly with the state it belongs to.
   always_comb begin
      state_next      = state_reg;
      shift_next      = shift_reg;
      parity_next     = parity_reg;
      bit_cnt_next    = bit_cnt_reg;
      tx_next         = tx_reg;
      frame_done_next = 1'b0;
      case (state_reg)
         IDLE: begin
            tx_next = 1'b1;
            if (en && !fifo_empty) state_next = FETCH;
         end
         FETCH: begin
            state_next = LOAD;
         end
         LOAD: begin
            shift_next   = fifo_dout;
            parity_next  = ^fifo_dout;
            bit_cnt_next = '0;
            tx_next      = 1'b0;
            state_next   = START;
         end
         START: begin
            if (bit_tick) begin
               tx_next    = shift_reg[0];
               state_next = DATA;
            end
         end
         DATA: begin
            if (bit_tick) begin
               if (bit_cnt_reg == LAST_BIT) begin
                  bit_cnt_next = '0;
                  if (PARITY_EN != 0) begin
                     tx_next    = parity_reg;
                     state_next = PARITY;
                  end else begin
                     tx_next    = 1'b1;
                     state_next = STOP;
                  end
               end else begin
                  bit_cnt_next = bit_cnt_reg + BW'(1);
                  shift_next   = shift_reg >> 1;
                  tx_next      = shift_next[0];
               end
            end
         end
         PARITY: begin
            if (bit_tick) begin
               tx_next    = 1'b1;
               state_next = STOP;
            end
         end
         STOP: begin
            tx_next = 1'b1;
            if (bit_tick) begin
               if (bit_cnt_reg == LAST_STOP) begin
                  bit_cnt_next    = '0;
                  frame_done_next = 1'b1;
                  state_next      = (en && !fifo_empty) ? FETCH : IDLE;
               end else begin
                  bit_cnt_next = bit_cnt_reg + BW'(1);
               end
            end
         end
         default: begin
            tx_next    = 1'b1;
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_reg      <= IDLE;
         shift_reg      <= '0;
         parity_reg     <= 1'b0;
         bit_cnt_reg    <= '0;
         tx_reg         <= 1'b1;
         rd_en_reg      <= 1'b0;
         frame_done_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         shift_reg      <= shift_next;
         parity_reg     <= parity_next;
         bit_cnt_reg    <= bit_cnt_next;
         tx_reg         <= tx_next;
         rd_en_reg      <= (state_next == FETCH);
         frame_done_reg <= frame_done_next;
      end
   end

   assign fifo_rd_en = rd_en_reg;
   assign tx         = tx_reg;
   assign busy       = (state_reg != IDLE);
   assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_fifo_word_serializer.sv
// Directed + randomized bench: two serializer configurations, each fed by a
// behavioural FIFO, with frames checked bit-by-bit against a word-level model.
module tb_fifo_word_serializer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int tests_run    = 0;
   int tests_failed = 0;

   // Configuration A: CLKS_PER_BIT=4, parity, 1 stop. B: CLKS_PER_BIT=2, no parity, 2 stops.
   logic        rstn_a, en_a, rd_en_a, tx_a, busy_a, fd_a, empty_a;
   logic        rstn_b, en_b, rd_en_b, tx_b, busy_b, fd_b, empty_b;
   logic [15:0] dout_a = 16'h0;
   logic [15:0] dout_b = 16'h0;
   logic [15:0] mem_a [0:255];
   logic [15:0] mem_b [0:255];
   int wp_a = 0, rp_a = 0, wp_b = 0, rp_b = 0;
   int rd_cnt_a = 0, fd_cnt_a = 0, under_a = 0;
   int rd_cnt_b = 0, fd_cnt_b = 0, under_b = 0;
   logic [15:0] exp_a[$];
   logic [15:0] exp_b[$];

   assign empty_a = (wp_a == rp_a);
   assign empty_b = (wp_b == rp_b);

   always @(posedge clk) begin
      if (rd_en_a) begin
         rd_cnt_a <= rd_cnt_a + 1;
         if (wp_a == rp_a) under_a <= under_a + 1;
         else begin
            dout_a <= mem_a[rp_a % 256];
            rp_a   <= rp_a + 1;
         end
      end
      if (fd_a) fd_cnt_a <= fd_cnt_a + 1;
      if (rd_en_b) begin
         rd_cnt_b <= rd_cnt_b + 1;
         if (wp_b == rp_b) under_b <= under_b + 1;
         else begin
            dout_b <= mem_b[rp_b % 256];
            rp_b   <= rp_b + 1;
         end
      end
      if (fd_b) fd_cnt_b <= fd_cnt_b + 1;
   end

   fifo_word_serializer #(
      .DWIDTH(16), .CLKS_PER_BIT(4), .PARITY_EN(1), .STOP_BITS(1)
   ) dut_a (
      .clk(clk), .rstn(rstn_a), .en(en_a), .fifo_empty(empty_a),
      .fifo_dout(dout_a), .fifo_rd_en(rd_en_a), .tx(tx_a),
      .busy(busy_a), .frame_done(fd_a)
   );

   fifo_word_serializer #(
      .DWIDTH(16), .CLKS_PER_BIT(2), .PARITY_EN(0), .STOP_BITS(2)
   ) dut_b (
      .clk(clk), .rstn(rstn_b), .en(en_b), .fifo_empty(empty_b),
      .fifo_dout(dout_b), .fifo_rd_en(rd_en_b), .tx(tx_b),
      .busy(busy_b), .frame_done(fd_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests_run++;
      assert (obs === expv) else begin
         tests_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic logic tx_of(input bit sel);
      return sel ? tx_b : tx_a;
   endfunction

   function automatic logic busy_of(input bit sel);
      return sel ? busy_b : busy_a;
   endfunction

   function automatic logic fd_of(input bit sel);
      return sel ? fd_b : fd_a;
   endfunction

   task automatic push(input bit sel, input logic [15:0] w);
      if (sel) begin
         mem_b[wp_b % 256] = w;
         wp_b++;
         exp_b.push_back(w);
      end else begin
         mem_a[wp_a % 256] = w;
         wp_a++;
         exp_a.push_back(w);
      end
   endtask

   // Waits for the start bit, then checks every cycle of the frame against
   // the bit list derived from the next expected word.
   task automatic check_frame(input bit sel, input bit chk_gap, input int drop_en_at);
      logic [15:0] w;
      logic        bits[$];
      int          cpb, k, fd0;
      w   = sel ? exp_b.pop_front() : exp_a.pop_front();
      cpb = sel ? 2 : 4;
      bits.push_back(1'b0);
      for (int i = 0; i < 16; i++) bits.push_back(w[i]);
      if (!sel) bits.push_back(^w);
      bits.push_back(1'b1);
      if (sel) bits.push_back(1'b1);
      k = 0;
      while (tx_of(sel) !== 1'b0 && k < 3000) begin
         @(negedge clk);
         k++;
      end
      chk("frame_start_seen", tx_of(sel), 1'b0);
      if (tx_of(sel) !== 1'b0) return;
      if (chk_gap) chk("back_to_back_gap", k, 2);
      chk("busy_in_frame", busy_of(sel), 1'b1);
      fd0 = sel ? fd_cnt_b : fd_cnt_a;
      for (int j = 0; j < bits.size() * cpb; j++) begin
         if (j > 0) @(negedge clk);
         if (j == drop_en_at) en_a = 1'b0;
         chk($sformatf("tx_word%04h_cyc%0d", w, j), tx_of(sel), bits[j / cpb]);
      end
      @(negedge clk);
      chk("frame_done_pulse", fd_of(sel), 1'b1);
      chk("frame_done_none_early", sel ? fd_cnt_b : fd_cnt_a, fd0);
      $display("[TB] frame word=%04h cfg=%0d cycles=%0d", w, sel, bits.size() * cpb);
   endtask

   initial begin
      logic [15:0] rw;
      int          k;
      rstn_a = 1'b0; rstn_b = 1'b0; en_a = 1'b0; en_b = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_tx", tx_a, 1'b1);
      chk("reset_busy", busy_a, 1'b0);
      chk("reset_rd_en", rd_en_a, 1'b0);
      chk("reset_frame_done", fd_a, 1'b0);
      chk("reset_tx_b", tx_b, 1'b1);
      rstn_a = 1'b1; rstn_b = 1'b1;
      @(negedge clk);

      // Enabled but empty FIFO: nothing may happen.
      en_a = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         chk("empty_rd_en", rd_en_a, 1'b0);
         chk("empty_tx", tx_a, 1'b1);
         chk("empty_busy", busy_a, 1'b0);
      end
      chk("empty_rd_count", rd_cnt_a, 0);

      // Single known word.
      push(1'b0, 16'hA5C3);
      check_frame(1'b0, 1'b0, -1);
      repeat (5) @(negedge clk);
      chk("single_idle", busy_a, 1'b0);
      chk("single_rd_count", rd_cnt_a, 1);
      chk("single_fd_count", fd_cnt_a, 1);

      // Three queued words sent back to back.
      en_a = 1'b0;
      push(1'b0, 16'h0001); push(1'b0, 16'hFFFF); push(1'b0, 16'h8000);
      repeat (3) @(negedge clk);
      chk("en_low_holds_idle", busy_a, 1'b0);
      en_a = 1'b1;
      check_frame(1'b0, 1'b0, -1);
      check_frame(1'b0, 1'b1, -1);
      check_frame(1'b0, 1'b1, -1);
      repeat (5) @(negedge clk);
      chk("three_rd_count", rd_cnt_a, 4);
      chk("three_fd_count", fd_cnt_a, 4);
      chk("three_idle", busy_a, 1'b0);

      // Random words, back to back.
      for (int i = 0; i < 6; i++) begin
         rw = 16'($urandom);
         push(1'b0, rw);
      end
      for (int i = 0; i < 6; i++) check_frame(1'b0, i > 0, -1);
      repeat (5) @(negedge clk);
      chk("random_rd_count", rd_cnt_a, 10);

      // en dropped during data bit 3: frame finishes, second word stays queued.
      push(1'b0, 16'h1234); push(1'b0, 16'hBEEF);
      check_frame(1'b0, 1'b0, 16);
      repeat (40) @(negedge clk);
      chk("en_drop_rd_count", rd_cnt_a, 11);
      chk("en_drop_idle", busy_a, 1'b0);
      chk("en_drop_tx", tx_a, 1'b1);
      en_a = 1'b1;
      check_frame(1'b0, 1'b0, -1);
      repeat (5) @(negedge clk);
      chk("en_resume_rd_count", rd_cnt_a, 12);

      // Reset during data bit 7: partial word is lost, next word follows.
      push(1'b0, 16'h5A5A); push(1'b0, 16'h0F0F);
      k = 0;
      while (tx_a !== 1'b0 && k < 3000) begin
         @(negedge clk);
         k++;
      end
      chk("rst_frame_start", tx_a, 1'b0);
      repeat ((1 + 7) * 4 + 1) @(negedge clk);
      #2 rstn_a = 1'b0;
      #1;
      chk("rst_mid_tx", tx_a, 1'b1);
      chk("rst_mid_busy", busy_a, 1'b0);
      chk("rst_mid_rd_en", rd_en_a, 1'b0);
      void'(exp_a.pop_front());
      repeat (3) @(negedge clk);
      rstn_a = 1'b1;
      check_frame(1'b0, 1'b0, -1);
      repeat (5) @(negedge clk);
      chk("rst_rd_count", rd_cnt_a, 14);
      chk("rst_idle", busy_a, 1'b0);

      // Configuration B: no parity, two stop bits, 38-cycle frames.
      en_b = 1'b1;
      rw = 16'($urandom); push(1'b1, rw);
      rw = 16'($urandom); push(1'b1, rw);
      check_frame(1'b1, 1'b0, -1);
      check_frame(1'b1, 1'b1, -1);
      repeat (5) @(negedge clk);
      chk("b_rd_count", rd_cnt_b, 2);
      chk("b_idle", busy_b, 1'b0);

      chk("fifo_underflow_a", under_a, 0);
      chk("fifo_underflow_b", under_b, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/fifo_word_serializer.md
FIFO_WORD_SERIALIZER -- requirements
Module: fifo_word_serializer

Interface
REQ-001 SHALL have parameter DWIDTH, default 16: word width read from the upstream sync FIFO.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 8: clk cycles per serial bit, legal range 2..65535.
REQ-003 SHALL have parameter PARITY_EN, default 1: 1 inserts an even-parity bit after the data bits; 0 omits it.
REQ-004 SHALL have parameter STOP_BITS, default 1: number of stop bits, legal values 1 or 2.
REQ-005 SHALL have port clk, input, 1: single clock; all logic is on the rising edge.
REQ-006 SHALL have port rstn, input, 1: reset, asynchronous assert, active-low.
REQ-007 SHALL have port en, input, 1: permits the start of new frames.
REQ-008 SHALL have port fifo_empty, input, 1: the upstream FIFO empty flag.
REQ-009 SHALL have port fifo_dout, input, DWIDTH: the upstream FIFO read data, registered and valid 1 cycle after an accepted read.
REQ-010 SHALL have port fifo_rd_en, output, 1: read strobe to the upstream FIFO.
REQ-011 SHALL have port tx, output, 1: serial line, idle high.
REQ-012 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-013 SHALL have port frame_done, output, 1: 1-cycle pulse at the end of the last stop bit.

Function
REQ-014 SHALL implement the states IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
REQ-015 IDLE SHALL go to FETCH when en=1 and fifo_empty=0; otherwise it SHALL stay in IDLE.
REQ-016 fifo_rd_en SHALL be registered, high only for the single cycle spent in FETCH, and never high while fifo_empty=1 was sampled in the preceding cycle.
REQ-017 FETCH SHALL go to LOAD unconditionally.
REQ-018 LOAD SHALL capture fifo_dout into the shift register and then go to START.
REQ-019 START SHALL drive tx=0 for CLKS_PER_BIT cycles.
REQ-020 DATA SHALL shift out DWIDTH bits LSB first, each for CLKS_PER_BIT cycles.
REQ-021 PARITY SHALL drive the XOR of the captured word for CLKS_PER_BIT cycles, and SHALL be skipped when PARITY_EN=0.
REQ-022 STOP SHALL drive tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
REQ-023 After STOP, the block SHALL pulse frame_done, then go to FETCH if en=1 and fifo_empty=0, else to IDLE (back-to-back frames with no idle gap beyond FETCH+LOAD).
REQ-024 The frame length from the first START cycle to the end of STOP SHALL be (1+DWIDTH+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles.
REQ-025 The bit counter SHALL be $clog2(DWIDTH+1) wide.
REQ-026 The baud counter SHALL be $clog2(CLKS_PER_BIT) wide and SHALL wrap from CLKS_PER_BIT-1 to 0, producing a bit_tick.
REQ-027 Deasserting en mid-frame SHALL NOT abort the frame; it only blocks the next FETCH.
REQ-028 Changes on fifo_empty outside IDLE and the STOP exit SHALL be ignored.
REQ-029 tx SHALL be registered and glitch-free.

Reset
REQ-030 While rstn=0: state=IDLE, tx=1, fifo_rd_en=0, busy=0, frame_done=0, shift register=0, counters=0.
REQ-031 Reset asserted mid-frame SHALL drive tx high immediately and SHALL discard the partial word without re-reading it.
REQ-032 Reset deassertion SHALL take effect on the first clk edge after rstn rises.

Structure
REQ-033 Package fifo_ser_pkg SHALL hold the state enum typedef and the STOP_BITS legal-value constants.
REQ-034 The baud counter SHALL be sub-module ser_bit_timer: inputs clk, rstn, run; output bit_tick; parameter CLKS_PER_BIT.
REQ-035 The top SHALL be the FSM plus the datapath, in 120-400 lines of RTL in total.

Verification
REQ-036 Single word, DWIDTH=16, CLKS_PER_BIT=4, PARITY_EN=1: 0xA5C3 -> tx = 0, bits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1, parity 0, 1; frame 76 cycles; one frame_done.
REQ-037 Empty FIFO with en=1 held for 100 cycles -> fifo_rd_en never asserted, tx=1, busy=0.
REQ-038 Three words queued (0x0001, 0xFFFF, 0x8000) -> three back-to-back frames, exactly 3 fifo_rd_en pulses, parity 1, 0, 1.
REQ-039 en dropped during DATA of frame 1 while two words are queued -> frame 1 completes, no further fifo_rd_en, state returns to IDLE.
REQ-040 rstn pulsed low at data bit 7 -> tx=1 asynchronously, busy=0; after release with the FIFO non-empty, the next frame carries the next FIFO word.
REQ-041 PARITY_EN=0, STOP_BITS=2, CLKS_PER_BIT=2 -> frame is 38 cycles, with tx=1 for the final 4 cycles.
